// File: rtl/mem_arbiter_if.sv
// Core-side and memory-side signal bundle for mem_arbiter.
// The arbiter binds the slave modport; the core and memory side binds master.
interface mem_arbiter_if;
   // Handshake: a master raises req and holds addr/wstrb/wdata stable until gnt
   // is seen high in the same cycle (gnt is combinational on req). Every grant
   // yields exactly one rvalid pulse on that master's port, RD_LATENCY cycles
   // after the grant, with err marking an out-of-range access.
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        i_err;

   logic        d_req;
   logic [3:0]  d_wstrb;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        d_err;

   logic        mem_re;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   modport slave (
      input  i_req, i_addr, d_req, d_wstrb, d_addr, d_wdata, mem_rd,
      output i_gnt, i_rvalid, i_rdata, i_err,
      output d_gnt, d_rvalid, d_rdata, d_err,
      output mem_re, mem_wstrb, mem_a, mem_wd
   );

   modport master (
      output i_req, i_addr, d_req, d_wstrb, d_addr, d_wdata, mem_rd,
      input  i_gnt, i_rvalid, i_rdata, i_err,
      input  d_gnt, d_rvalid, d_rdata, d_err,
      input  mem_re, mem_wstrb, mem_a, mem_wd
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master (fetch I, load/store D) arbiter in front of one single-port memory.
// One grant per cycle; responses are tagged and routed back after RD_LATENCY cycles.
module mem_arbiter #(
   parameter int          RD_LATENCY = 1,
   parameter int          ARB_MODE   = 0,
   parameter logic [31:0] ADDR_LIMIT = 32'h0000_2000
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.slave  bus,
   output logic          dbg_rr_ptr
);

   logic rr_ptr;
   logic i_in_range;
   logic d_in_range;
   logic pick_d;
   logic gnt_i;
   logic gnt_d;
   logic gnt_any;
   logic gnt_write;
   logic gnt_err;

   logic        resp_valid;
   logic        resp_d;
   logic        resp_write;
   logic        resp_err;
   logic [31:0] resp_data;

   assign i_in_range = (bus.i_addr < ADDR_LIMIT);
   assign d_in_range = (bus.d_addr < ADDR_LIMIT);

   // rr_ptr=0 prefers D on a tie, rr_ptr=1 prefers I; fixed mode always prefers D.
   always_comb begin
      pick_d = 1'b0;
      if (bus.d_req && bus.i_req) begin
         pick_d = (ARB_MODE == 1) ? 1'b1 : !rr_ptr;
      end else begin
         pick_d = bus.d_req;
      end
   end

   // No grants while reset is held so the memory stays idle.
   assign gnt_d     = reset & bus.d_req & pick_d;
   assign gnt_i     = reset & bus.i_req & !pick_d;
   assign gnt_any   = gnt_d | gnt_i;
   assign gnt_write = gnt_d & (bus.d_wstrb != 4'd0);

   always_comb begin
      gnt_err = 1'b0;
      if (gnt_d) begin
         gnt_err = !d_in_range;
      end else if (gnt_i) begin
         gnt_err = !i_in_range;
      end
   end

   assign bus.d_gnt = gnt_d;
   assign bus.i_gnt = gnt_i;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr <= 1'b0;
      end else if (gnt_any) begin
         rr_ptr <= gnt_d;
      end
   end

   assign dbg_rr_ptr = rr_ptr;

   // Out-of-range grants still answer, but never reach the memory.
   always_comb begin
      bus.mem_re    = 1'b0;
      bus.mem_wstrb = 4'd0;
      bus.mem_a     = 32'd0;
      bus.mem_wd    = 32'd0;
      if (gnt_d && d_in_range) begin
         bus.mem_a = bus.d_addr;
         if (gnt_write) begin
            bus.mem_wstrb = bus.d_wstrb;
            bus.mem_wd    = bus.d_wdata;
         end else begin
            bus.mem_re = 1'b1;
         end
      end else if (gnt_i && i_in_range) begin
         bus.mem_a  = bus.i_addr;
         bus.mem_re = 1'b1;
      end
   end

   generate
      if (RD_LATENCY == 0) begin : g_comb_resp
         assign resp_valid = gnt_any;
         assign resp_d     = gnt_d;
         assign resp_write = gnt_write;
         assign resp_err   = gnt_err;
      end else begin : g_reg_resp
         // Tag captured at grant lines up with the registered memory read data.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               resp_valid <= 1'b0;
               resp_d     <= 1'b0;
               resp_write <= 1'b0;
               resp_err   <= 1'b0;
            end else begin
               resp_valid <= gnt_any;
               resp_d     <= gnt_d;
               resp_write <= gnt_write;
               resp_err   <= gnt_err;
            end
         end
      end
   endgenerate

   assign resp_data = (resp_write || resp_err) ? 32'd0 : bus.mem_rd;

   assign bus.d_rvalid = resp_valid & resp_d;
   assign bus.d_err    = resp_valid & resp_d & resp_err;
   assign bus.d_rdata  = (resp_valid && resp_d) ? resp_data : 32'd0;

   assign bus.i_rvalid = resp_valid & !resp_d;
   assign bus.i_err    = resp_valid & !resp_d & resp_err;
   assign bus.i_rdata  = (resp_valid && !resp_d) ? resp_data : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin, fixed-priority and zero-latency
// instances share one stimulus set, each with its own memory model.
module tb_mem_arbiter;

   logic clk;
   logic rst_n;
   logic load_mem;
   int   checks;
   int   failures;

   logic        i_req;
   logic [31:0] i_addr;
   logic        d_req;
   logic [3:0]  d_wstrb;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;

   logic dbg_rr, dbg_fp, dbg_l0;
   logic [31:0] rd_rr, rd_fp, rd_l0;
   logic [31:0] mem_rr [0:2047];
   logic [31:0] mem_fp [0:2047];
   logic [31:0] mem_l0 [0:2047];

   mem_arbiter_if bus_rr ();
   mem_arbiter_if bus_fp ();
   mem_arbiter_if bus_l0 ();

   mem_arbiter #(.RD_LATENCY(1), .ARB_MODE(0), .ADDR_LIMIT(32'h2000)) dut_rr (
      .clk(clk), .reset(rst_n), .bus(bus_rr.slave), .dbg_rr_ptr(dbg_rr));
   mem_arbiter #(.RD_LATENCY(1), .ARB_MODE(1), .ADDR_LIMIT(32'h2000)) dut_fp (
      .clk(clk), .reset(rst_n), .bus(bus_fp.slave), .dbg_rr_ptr(dbg_fp));
   mem_arbiter #(.RD_LATENCY(0), .ARB_MODE(0), .ADDR_LIMIT(32'h2000)) dut_l0 (
      .clk(clk), .reset(rst_n), .bus(bus_l0.slave), .dbg_rr_ptr(dbg_l0));

   assign bus_rr.i_req = i_req;  assign bus_rr.i_addr = i_addr;
   assign bus_rr.d_req = d_req;  assign bus_rr.d_wstrb = d_wstrb;
   assign bus_rr.d_addr = d_addr; assign bus_rr.d_wdata = d_wdata;
   assign bus_rr.mem_rd = rd_rr;
   assign bus_fp.i_req = i_req;  assign bus_fp.i_addr = i_addr;
   assign bus_fp.d_req = d_req;  assign bus_fp.d_wstrb = d_wstrb;
   assign bus_fp.d_addr = d_addr; assign bus_fp.d_wdata = d_wdata;
   assign bus_fp.mem_rd = rd_fp;
   assign bus_l0.i_req = i_req;  assign bus_l0.i_addr = i_addr;
   assign bus_l0.d_req = d_req;  assign bus_l0.d_wstrb = d_wstrb;
   assign bus_l0.d_addr = d_addr; assign bus_l0.d_wdata = d_wdata;
   assign bus_l0.mem_rd = rd_l0;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int k);
      logic [31:0] kv;
      kv = k;
      if (k == 4) return 32'hDEADBEEF;
      if (k == 8) return 32'h11223344;
      return {16'hC0DE, kv[15:0]};
   endfunction

   // ---------------- memory models ----------------
   always @(posedge clk) begin
      if (load_mem) begin
         for (int k = 0; k < 2048; k++) mem_rr[k] <= init_word(k);
      end else begin
         for (int b = 0; b < 4; b++)
            if (bus_rr.mem_wstrb[b]) mem_rr[bus_rr.mem_a[12:2]][8*b +: 8] <= bus_rr.mem_wd[8*b +: 8];
         if (bus_rr.mem_re) rd_rr <= mem_rr[bus_rr.mem_a[12:2]];
      end
   end

   always @(posedge clk) begin
      if (load_mem) begin
         for (int k = 0; k < 2048; k++) mem_fp[k] <= init_word(k);
      end else begin
         for (int b = 0; b < 4; b++)
            if (bus_fp.mem_wstrb[b]) mem_fp[bus_fp.mem_a[12:2]][8*b +: 8] <= bus_fp.mem_wd[8*b +: 8];
         if (bus_fp.mem_re) rd_fp <= mem_fp[bus_fp.mem_a[12:2]];
      end
   end

   always @(posedge clk) begin
      if (load_mem) begin
         for (int k = 0; k < 2048; k++) mem_l0[k] <= init_word(k);
      end else begin
         for (int b = 0; b < 4; b++)
            if (bus_l0.mem_wstrb[b]) mem_l0[bus_l0.mem_a[12:2]][8*b +: 8] <= bus_l0.mem_wd[8*b +: 8];
      end
   end
   assign rd_l0 = mem_l0[bus_l0.mem_a[12:2]];

   // ---------------- driver tasks ----------------
   task automatic idle();
      i_req = 1'b0; i_addr = 32'd0;
      d_req = 1'b0; d_wstrb = 4'd0; d_addr = 32'd0; d_wdata = 32'd0;
   endtask

   task automatic test_reset();
      i_req = 1'b1; i_addr = 32'h10;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (bus_rr.i_gnt !== 1'b0) begin failures++; $display("FAIL rst_i_gnt got=%h exp=0", bus_rr.i_gnt); end
      checks++; if (bus_rr.mem_re !== 1'b0) begin failures++; $display("FAIL rst_mem_re got=%h exp=0", bus_rr.mem_re); end
      checks++; if (bus_rr.mem_wstrb !== 4'd0) begin failures++; $display("FAIL rst_mem_wstrb got=%h exp=0", bus_rr.mem_wstrb); end
      checks++; if (bus_rr.i_rvalid !== 1'b0) begin failures++; $display("FAIL rst_i_rvalid got=%h exp=0", bus_rr.i_rvalid); end
      checks++; if (bus_rr.d_rvalid !== 1'b0) begin failures++; $display("FAIL rst_d_rvalid got=%h exp=0", bus_rr.d_rvalid); end
      checks++; if (bus_rr.i_rdata !== 32'd0) begin failures++; $display("FAIL rst_i_rdata got=%h exp=0", bus_rr.i_rdata); end
      checks++; if (dbg_rr !== 1'b0) begin failures++; $display("FAIL rst_rr_ptr got=%h exp=0", dbg_rr); end
      checks++; if (bus_l0.i_rvalid !== 1'b0) begin failures++; $display("FAIL rst_l0_i_rvalid got=%h exp=0", bus_l0.i_rvalid); end
      @(negedge clk);
      load_mem = 1'b0; rst_n = 1'b1;
      #1;
      checks++; if (bus_rr.i_gnt !== 1'b1) begin failures++; $display("FAIL rel_i_gnt got=%h exp=1", bus_rr.i_gnt); end
      checks++; if (bus_rr.d_gnt !== 1'b0) begin failures++; $display("FAIL rel_d_gnt got=%h exp=0", bus_rr.d_gnt); end
      checks++; if (bus_rr.mem_re !== 1'b1) begin failures++; $display("FAIL rel_mem_re got=%h exp=1", bus_rr.mem_re); end
      checks++; if (bus_rr.mem_a !== 32'h10) begin failures++; $display("FAIL rel_mem_a got=%h exp=10", bus_rr.mem_a); end
      checks++; if (bus_l0.i_rvalid !== 1'b1) begin failures++; $display("FAIL l0_i_rvalid got=%h exp=1", bus_l0.i_rvalid); end
      checks++; if (bus_l0.i_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL l0_i_rdata got=%h exp=deadbeef", bus_l0.i_rdata); end
      @(negedge clk);
      i_req = 1'b0;
      #1;
      checks++; if (bus_rr.i_rvalid !== 1'b1) begin failures++; $display("FAIL rel_i_rvalid got=%h exp=1", bus_rr.i_rvalid); end
      checks++; if (bus_rr.i_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rel_i_rdata got=%h exp=deadbeef", bus_rr.i_rdata); end
      checks++; if (bus_rr.i_err !== 1'b0) begin failures++; $display("FAIL rel_i_err got=%h exp=0", bus_rr.i_err); end
      checks++; if (bus_rr.d_rvalid !== 1'b0) begin failures++; $display("FAIL rel_d_rvalid got=%h exp=0", bus_rr.d_rvalid); end
      @(negedge clk);
      #1;
      checks++; if (bus_rr.i_rvalid !== 1'b0) begin failures++; $display("FAIL rel_single_pulse got=%h exp=0", bus_rr.i_rvalid); end
   endtask

   task automatic test_round_robin();
      logic exp_d;
      logic prev_d;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k < 4) begin
            i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_addr = 32'h20; d_wstrb = 4'd0;
         end else begin
            idle();
         end
         #1;
         exp_d  = (k % 2 == 0);
         prev_d = (k % 2 == 1);
         if (k < 4) begin
            checks++; if (bus_rr.d_gnt !== exp_d) begin failures++; $display("FAIL rr_d_gnt[%0d] got=%h exp=%h", k, bus_rr.d_gnt, exp_d); end
            checks++; if (bus_rr.i_gnt !== !exp_d) begin failures++; $display("FAIL rr_i_gnt[%0d] got=%h exp=%h", k, bus_rr.i_gnt, !exp_d); end
         end
         checks++; if (bus_rr.d_gnt && bus_rr.i_gnt) begin failures++; $display("FAIL rr_both_gnt[%0d] got=1 exp=0", k); end
         if (k > 0) begin
            checks++; if (bus_rr.d_rvalid !== prev_d) begin failures++; $display("FAIL rr_d_rvalid[%0d] got=%h exp=%h", k, bus_rr.d_rvalid, prev_d); end
            checks++; if (bus_rr.i_rvalid !== !prev_d) begin failures++; $display("FAIL rr_i_rvalid[%0d] got=%h exp=%h", k, bus_rr.i_rvalid, !prev_d); end
            if (prev_d) begin
               checks++; if (bus_rr.d_rdata !== 32'h11223344) begin failures++; $display("FAIL rr_d_rdata[%0d] got=%h exp=11223344", k, bus_rr.d_rdata); end
               checks++; if (bus_rr.i_rdata !== 32'd0) begin failures++; $display("FAIL rr_i_rdata_idle[%0d] got=%h exp=0", k, bus_rr.i_rdata); end
            end else begin
               checks++; if (bus_rr.i_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rr_i_rdata[%0d] got=%h exp=deadbeef", k, bus_rr.i_rdata); end
               checks++; if (bus_rr.d_rdata !== 32'd0) begin failures++; $display("FAIL rr_d_rdata_idle[%0d] got=%h exp=0", k, bus_rr.d_rdata); end
            end
         end
      end
   endtask

   task automatic test_fixed_priority();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k < 3) begin
            i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_addr = 32'h20; d_wstrb = 4'd0;
         end else if (k == 3) begin
            d_req = 1'b0;
         end else begin
            idle();
         end
         #1;
         if (k < 3) begin
            checks++; if (bus_fp.d_gnt !== 1'b1) begin failures++; $display("FAIL fp_d_gnt[%0d] got=%h exp=1", k, bus_fp.d_gnt); end
            checks++; if (bus_fp.i_gnt !== 1'b0) begin failures++; $display("FAIL fp_i_gnt[%0d] got=%h exp=0", k, bus_fp.i_gnt); end
         end else if (k == 3) begin
            checks++; if (bus_fp.i_gnt !== 1'b1) begin failures++; $display("FAIL fp_i_gnt_after got=%h exp=1", bus_fp.i_gnt); end
         end else begin
            checks++; if (bus_fp.i_rvalid !== 1'b1) begin failures++; $display("FAIL fp_i_rvalid got=%h exp=1", bus_fp.i_rvalid); end
            checks++; if (bus_fp.i_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL fp_i_rdata got=%h exp=deadbeef", bus_fp.i_rdata); end
         end
      end
   endtask

   task automatic test_write_merge();
      @(negedge clk);
      d_req = 1'b1; d_wstrb = 4'b0010; d_addr = 32'h20; d_wdata = 32'h0000AB00;
      #1;
      checks++; if (bus_rr.d_gnt !== 1'b1) begin failures++; $display("FAIL wr_d_gnt got=%h exp=1", bus_rr.d_gnt); end
      checks++; if (bus_rr.mem_wstrb !== 4'b0010) begin failures++; $display("FAIL wr_mem_wstrb got=%h exp=2", bus_rr.mem_wstrb); end
      checks++; if (bus_rr.mem_wd !== 32'h0000AB00) begin failures++; $display("FAIL wr_mem_wd got=%h exp=0000ab00", bus_rr.mem_wd); end
      checks++; if (bus_rr.mem_re !== 1'b0) begin failures++; $display("FAIL wr_mem_re got=%h exp=0", bus_rr.mem_re); end
      checks++; if (bus_l0.d_rvalid !== 1'b1 || bus_l0.d_rdata !== 32'd0) begin failures++; $display("FAIL l0_wr_resp got=%h/%h exp=1/0", bus_l0.d_rvalid, bus_l0.d_rdata); end
      @(negedge clk);
      d_wstrb = 4'd0; d_wdata = 32'd0;
      #1;
      checks++; if (bus_rr.d_rvalid !== 1'b1) begin failures++; $display("FAIL wr_d_rvalid got=%h exp=1", bus_rr.d_rvalid); end
      checks++; if (bus_rr.d_rdata !== 32'd0) begin failures++; $display("FAIL wr_d_rdata got=%h exp=0", bus_rr.d_rdata); end
      checks++; if (bus_rr.mem_re !== 1'b1 || bus_rr.mem_wstrb !== 4'd0) begin failures++; $display("FAIL rd_mem_drive got=%h/%h exp=1/0", bus_rr.mem_re, bus_rr.mem_wstrb); end
      checks++; if (bus_l0.d_rdata !== 32'h1122AB44) begin failures++; $display("FAIL l0_rd_merge got=%h exp=1122ab44", bus_l0.d_rdata); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (bus_rr.d_rvalid !== 1'b1) begin failures++; $display("FAIL rd_d_rvalid got=%h exp=1", bus_rr.d_rvalid); end
      checks++; if (bus_rr.d_rdata !== 32'h1122AB44) begin failures++; $display("FAIL rd_merge got=%h exp=1122ab44", bus_rr.d_rdata); end
   endtask

   task automatic test_same_addr();
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h24;
      d_req = 1'b1; d_wstrb = 4'hF; d_addr = 32'h24; d_wdata = 32'hCAFEF00D;
      #1;
      checks++; if (bus_fp.d_gnt !== 1'b1 || bus_fp.i_gnt !== 1'b0) begin failures++; $display("FAIL same_gnt0 got=%h/%h exp=1/0", bus_fp.d_gnt, bus_fp.i_gnt); end
      checks++; if (bus_fp.mem_wstrb !== 4'hF) begin failures++; $display("FAIL same_wstrb got=%h exp=f", bus_fp.mem_wstrb); end
      @(negedge clk);
      d_req = 1'b0; d_wstrb = 4'd0; d_wdata = 32'd0;
      #1;
      checks++; if (bus_fp.i_gnt !== 1'b1 || bus_fp.mem_re !== 1'b1) begin failures++; $display("FAIL same_gnt1 got=%h/%h exp=1/1", bus_fp.i_gnt, bus_fp.mem_re); end
      checks++; if (bus_fp.mem_wstrb !== 4'd0 || bus_fp.mem_a !== 32'h24) begin failures++; $display("FAIL same_i_drive got=%h/%h exp=0/24", bus_fp.mem_wstrb, bus_fp.mem_a); end
      checks++; if (bus_fp.d_rvalid !== 1'b1 || bus_fp.d_rdata !== 32'd0) begin failures++; $display("FAIL same_wr_resp got=%h/%h exp=1/0", bus_fp.d_rvalid, bus_fp.d_rdata); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (bus_fp.i_rvalid !== 1'b1) begin failures++; $display("FAIL same_i_rvalid got=%h exp=1", bus_fp.i_rvalid); end
      checks++; if (bus_fp.i_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL same_i_rdata got=%h exp=cafef00d", bus_fp.i_rdata); end
      checks++; if (bus_fp.d_rvalid !== 1'b0) begin failures++; $display("FAIL same_d_quiet got=%h exp=0", bus_fp.d_rvalid); end
   endtask

   task automatic test_out_of_range();
      @(negedge clk);
      d_req = 1'b1; d_wstrb = 4'd0; d_addr = 32'h2000;
      #1;
      checks++; if (bus_rr.d_gnt !== 1'b1) begin failures++; $display("FAIL oor_d_gnt got=%h exp=1", bus_rr.d_gnt); end
      checks++; if (bus_rr.mem_re !== 1'b0 || bus_rr.mem_wstrb !== 4'd0) begin failures++; $display("FAIL oor_mem_idle got=%h/%h exp=0/0", bus_rr.mem_re, bus_rr.mem_wstrb); end
      checks++; if (bus_rr.mem_a !== 32'd0) begin failures++; $display("FAIL oor_mem_a got=%h exp=0", bus_rr.mem_a); end
      checks++; if (bus_l0.d_err !== 1'b1 || bus_l0.d_rdata !== 32'd0) begin failures++; $display("FAIL l0_oor got=%h/%h exp=1/0", bus_l0.d_err, bus_l0.d_rdata); end
      @(negedge clk);
      d_addr = 32'h1FFC;
      #1;
      checks++; if (bus_rr.d_rvalid !== 1'b1 || bus_rr.d_err !== 1'b1) begin failures++; $display("FAIL oor_resp got=%h/%h exp=1/1", bus_rr.d_rvalid, bus_rr.d_err); end
      checks++; if (bus_rr.d_rdata !== 32'd0) begin failures++; $display("FAIL oor_rdata got=%h exp=0", bus_rr.d_rdata); end
      checks++; if (bus_rr.mem_re !== 1'b1 || bus_rr.mem_a !== 32'h1FFC) begin failures++; $display("FAIL edge_drive got=%h/%h exp=1/1ffc", bus_rr.mem_re, bus_rr.mem_a); end
      @(negedge clk);
      d_addr = 32'h2000; d_wstrb = 4'hF; d_wdata = 32'h55AA55AA;
      #1;
      checks++; if (bus_rr.d_rvalid !== 1'b1 || bus_rr.d_err !== 1'b0) begin failures++; $display("FAIL edge_resp got=%h/%h exp=1/0", bus_rr.d_rvalid, bus_rr.d_err); end
      checks++; if (bus_rr.d_rdata !== 32'hC0DE07FF) begin failures++; $display("FAIL edge_rdata got=%h exp=c0de07ff", bus_rr.d_rdata); end
      checks++; if (bus_rr.mem_wstrb !== 4'd0 || bus_rr.mem_wd !== 32'd0) begin failures++; $display("FAIL oor_wr_idle got=%h/%h exp=0/0", bus_rr.mem_wstrb, bus_rr.mem_wd); end
      @(negedge clk);
      idle();
      i_req = 1'b1; i_addr = 32'h2000;
      #1;
      checks++; if (dbg_rr !== 1'b1) begin failures++; $display("FAIL rr_ptr_after_d got=%h exp=1", dbg_rr); end
      checks++; if (bus_rr.d_err !== 1'b1 || bus_rr.d_rdata !== 32'd0) begin failures++; $display("FAIL oor_wr_resp got=%h/%h exp=1/0", bus_rr.d_err, bus_rr.d_rdata); end
      checks++; if (bus_rr.i_gnt !== 1'b1 || bus_rr.mem_re !== 1'b0) begin failures++; $display("FAIL oor_i_drive got=%h/%h exp=1/0", bus_rr.i_gnt, bus_rr.mem_re); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (bus_rr.i_rvalid !== 1'b1 || bus_rr.i_err !== 1'b1) begin failures++; $display("FAIL oor_i_resp got=%h/%h exp=1/1", bus_rr.i_rvalid, bus_rr.i_err); end
      checks++; if (bus_rr.i_rdata !== 32'd0 || bus_rr.d_rvalid !== 1'b0) begin failures++; $display("FAIL oor_i_rdata got=%h/%h exp=0/0", bus_rr.i_rdata, bus_rr.d_rvalid); end
   endtask

   task automatic test_reset_midstream();
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h10;
      #1;
      checks++; if (bus_rr.i_gnt !== 1'b1) begin failures++; $display("FAIL mid_i_gnt got=%h exp=1", bus_rr.i_gnt); end
      @(negedge clk);
      rst_n = 1'b0;
      d_req = 1'b1; d_addr = 32'h20; d_wstrb = 4'd0;
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++; if (bus_rr.i_rvalid !== 1'b0 || bus_rr.i_rdata !== 32'd0) begin failures++; $display("FAIL mid_rst_i_resp[%0d] got=%h/%h exp=0/0", k, bus_rr.i_rvalid, bus_rr.i_rdata); end
         checks++; if (bus_rr.i_gnt !== 1'b0 || bus_rr.d_gnt !== 1'b0) begin failures++; $display("FAIL mid_rst_gnt[%0d] got=%h/%h exp=0/0", k, bus_rr.i_gnt, bus_rr.d_gnt); end
         checks++; if (bus_rr.mem_re !== 1'b0) begin failures++; $display("FAIL mid_rst_mem_re[%0d] got=%h exp=0", k, bus_rr.mem_re); end
         @(negedge clk);
      end
      checks++; if (dbg_rr !== 1'b0) begin failures++; $display("FAIL mid_rr_ptr got=%h exp=0", dbg_rr); end
      rst_n = 1'b1;
      #1;
      checks++; if (bus_rr.d_gnt !== 1'b1 || bus_rr.i_gnt !== 1'b0) begin failures++; $display("FAIL mid_first_gnt got=%h/%h exp=1/0", bus_rr.d_gnt, bus_rr.i_gnt); end
      checks++; if (bus_rr.i_rvalid !== 1'b0 || bus_rr.d_rvalid !== 1'b0) begin failures++; $display("FAIL mid_stale got=%h/%h exp=0/0", bus_rr.i_rvalid, bus_rr.d_rvalid); end
      @(negedge clk);
      #1;
      checks++; if (bus_rr.d_rvalid !== 1'b1 || bus_rr.d_rdata !== 32'h1122AB44) begin failures++; $display("FAIL mid_d_resp got=%h/%h exp=1/1122ab44", bus_rr.d_rvalid, bus_rr.d_rdata); end
      checks++; if (bus_rr.i_gnt !== 1'b1 || bus_rr.i_rvalid !== 1'b0) begin failures++; $display("FAIL mid_i_turn got=%h/%h exp=1/0", bus_rr.i_gnt, bus_rr.i_rvalid); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (bus_rr.i_rvalid !== 1'b1 || bus_rr.i_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL mid_i_resp got=%h/%h exp=1/deadbeef", bus_rr.i_rvalid, bus_rr.i_rdata); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      checks   = 0;
      failures = 0;
      load_mem = 1'b1;
      rst_n    = 1'b0;
      idle();
      test_reset();
      test_round_robin();
      test_fixed_priority();
      test_write_merge();
      test_same_addr();
      test_out_of_range();
      test_reset_midstream();
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: sequence did not complete, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

endmodule
